// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Imported by the arbiter top level and its burst counter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  localparam logic [1:0] TAM_DOUBLE  = 2'd3;
  localparam int         MEM_LAT_MIN = 1;
  localparam int         MEM_LAT_MAX = 4;

  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/dmem_arb_burst_ctr.sv
// DMA burst bookkeeping: remaining-beat counter with last flag, and the
// address of the following beat (start + beat*DMA_STRIDE, wrapping at 2^64).
module dmem_arb_burst_ctr
  import dmem_arb_pkg::*;
#(
  parameter int DMA_STRIDE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [3:0]  len,
  input  logic [63:0] start,
  output logic [63:0] next_addr,
  output logic        last
);

  logic [4:0]  remaining;
  logic [3:0]  beat;
  logic [63:0] base;

  // A length of zero encodes a full 16-beat burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
      beat      <= '0;
      base      <= '0;
    end else if (load) begin
      remaining <= (len == 4'd0) ? 5'd16 : {1'b0, len};
      beat      <= '0;
      base      <= start;
    end else if (advance) begin
      remaining <= remaining - 5'd1;
      beat      <= beat + 4'd1;
    end
  end

  assign last      = (remaining == 5'd1);
  assign next_addr = base + (64'(beat) + 64'd1) * 64'(DMA_STRIDE);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read data-memory port between the CPU load/store
// path and a DMA engine, sequencing every access as ACC / WAIT / RESP.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int DMA_STRIDE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  input  logic [1:0]  cpu_tam,
  output logic [63:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [63:0] dma_addr,
  input  logic [3:0]  dma_len,
  input  logic [63:0] dma_wdata,
  output logic [63:0] dma_rdata,
  output logic        dma_beat_done,
  output logic        dma_done,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  output logic [1:0]  mem_tam,
  input  logic [63:0] mem_rdata
);

  if (!mem_lat_ok(MEM_LAT)) begin : g_bad_mem_lat
    $error("dmem_arbiter: MEM_LAT must lie in 1..4");
  end

  localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

  state_t      state;
  owner_t      owner;
  owner_t      last_grant;
  logic        we_q;
  logic [1:0]  lat_cnt;
  logic [63:0] wdata_q;
  logic        grant_cpu;
  logic        grant_dma;
  logic        resp_next;
  logic        burst_advance;
  logic        burst_last;
  logic [63:0] burst_next_addr;

  // On a tie the owner opposite the previous grant wins.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (state == IDLE) begin
      if (cpu_req && (!dma_req || last_grant == OWN_DMA)) begin
        grant_cpu = 1'b1;
      end else if (dma_req) begin
        grant_dma = 1'b1;
      end
    end
  end

  assign resp_next     = (state == ACC && we_q) || (state == WAIT && lat_cnt == 2'd0);
  assign burst_advance = (state == RESP) && (owner == OWN_DMA) && !burst_last;

  dmem_arb_burst_ctr #(
    .DMA_STRIDE (DMA_STRIDE)
  ) u_burst_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (grant_dma),
    .advance   (burst_advance),
    .len       (dma_len),
    .start     (dma_addr),
    .next_addr (burst_next_addr),
    .last      (burst_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= OWN_CPU;
      last_grant    <= OWN_DMA;
      we_q          <= 1'b0;
      lat_cnt       <= '0;
      wdata_q       <= '0;
      mem_addr      <= '0;
      mem_wr        <= 1'b0;
      mem_tam       <= '0;
      cpu_rdata     <= '0;
      dma_rdata     <= '0;
      cpu_done      <= 1'b0;
      dma_beat_done <= 1'b0;
      dma_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state      <= ACC;
            owner      <= OWN_CPU;
            last_grant <= OWN_CPU;
            we_q       <= cpu_we;
            mem_wr     <= cpu_we;
            mem_addr   <= cpu_addr;
            wdata_q    <= cpu_wdata;
            mem_tam    <= cpu_tam;
          end else if (grant_dma) begin
            state      <= ACC;
            owner      <= OWN_DMA;
            last_grant <= OWN_DMA;
            we_q       <= dma_we;
            mem_wr     <= dma_we;
            mem_addr   <= dma_addr;
            mem_tam    <= TAM_DOUBLE;
          end
        end
        ACC: begin
          mem_wr <= 1'b0;
          if (owner == OWN_DMA) begin
            wdata_q <= dma_wdata;
          end
          if (we_q) begin
            state <= RESP;
          end else begin
            state   <= WAIT;
            lat_cnt <= LAT_LOAD;
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            state <= RESP;
            if (owner == OWN_CPU) begin
              cpu_rdata <= mem_rdata;
            end else begin
              dma_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          // Bursts chain straight into the next beat without an IDLE cycle.
          if (burst_advance) begin
            state    <= ACC;
            mem_addr <= burst_next_addr;
            mem_wr   <= we_q;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      cpu_done      <= resp_next && (owner == OWN_CPU);
      dma_beat_done <= resp_next && (owner == OWN_DMA);
      dma_done      <= resp_next && (owner == OWN_DMA) && burst_last;
    end
  end

  // DMA write data is taken live during each beat's ACC cycle.
  assign mem_wdata = (state == ACC && owner == OWN_DMA) ? dma_wdata : wdata_q;
  assign cpu_stall = rst && cpu_req && !(state != IDLE && owner == OWN_CPU);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter with a latency-accurate
// memory device and an address-level reference model of expected contents.
module tb_dmem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int DMA_STRIDE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [63:0] cpu_addr = '0, cpu_wdata = '0;
  logic [1:0]  cpu_tam = '0;
  logic [63:0] cpu_rdata;
  logic        cpu_done, cpu_stall;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [63:0] dma_addr = '0, dma_wdata = '0;
  logic [3:0]  dma_len = '0;
  logic [63:0] dma_rdata;
  logic        dma_beat_done, dma_done;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr;
  logic [1:0]  mem_tam;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ref_last_dma = 1;

  typedef struct {
    int          cyc;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  tam;
  } wr_t;
  wr_t wr_log[$];

  logic [63:0] dev_mem [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] rd_pipe [MEM_LAT];

  dmem_arbiter #(
    .MEM_LAT    (MEM_LAT),
    .DMA_STRIDE (DMA_STRIDE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_tam       (cpu_tam),
    .cpu_rdata     (cpu_rdata),
    .cpu_done      (cpu_done),
    .cpu_stall     (cpu_stall),
    .dma_req       (dma_req),
    .dma_we        (dma_we),
    .dma_addr      (dma_addr),
    .dma_len       (dma_len),
    .dma_wdata     (dma_wdata),
    .dma_rdata     (dma_rdata),
    .dma_beat_done (dma_beat_done),
    .dma_done      (dma_done),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wr        (mem_wr),
    .mem_tam       (mem_tam),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [63:0] init_pat(input logic [63:0] a);
    return a ^ 64'hC3C3_3C3C_A5A5_5A5A;
  endfunction

  function automatic logic [63:0] dev_read(input logic [63:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_pat(a);
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
  endfunction

  // Memory device: writes land at the clock edge, reads appear MEM_LAT cycles later.
  always @(posedge clk) begin
    rd_pipe[0] <= dev_read(mem_addr);
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  always @(posedge clk) if (mem_wr) dev_mem[mem_addr] = mem_wdata;
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  always @(negedge clk) if (mem_wr === 1'b1) wr_log.push_back('{cyc, mem_addr, mem_wdata, mem_tam});

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic cpu_access(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [1:0] tam, output int k, output int done_cyc,
                            output logic [63:0] rdata);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_tam = tam;
    k = cyc; done_cyc = -1; rdata = '0;
    if (we) ref_mem[addr] = wdata;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (cpu_done) begin
        done_cyc = cyc;
        rdata    = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    check_output("cpu_done_seen", 64'(done_cyc >= 0), 64'd1);
  endtask

  task automatic dma_burst(input logic we, input logic [63:0] addr, input logic [3:0] len,
                           output int k, output int first_done);
    int n, period, beat, last_cyc;
    logic [63:0] a;
    logic [63:0] wq[$];
    n = (len == 4'd0) ? 16 : int'(len);
    period = we ? 2 : 2 + MEM_LAT;
    for (int i = 0; i < n; i++) wq.push_back({$urandom, $urandom});
    @(negedge clk);
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_len = len; dma_wdata = wq[0];
    k = cyc; first_done = -1; beat = 0; last_cyc = 0;
    for (int t = 0; t < 400 && beat < n; t++) begin
      @(negedge clk);
      if (dma_beat_done) begin
        a = addr + 64'(beat) * 64'(DMA_STRIDE);
        if (beat == 0) first_done = cyc;
        else check_output("dma_beat_spacing", 64'(cyc - last_cyc), 64'(period));
        check_output("dma_done_flag", 64'(dma_done), 64'(beat == n - 1));
        if (we) ref_mem[a] = wq[beat];
        else check_output("dma_rdata", dma_rdata, ref_read(a));
        last_cyc = cyc;
        beat++;
        if (beat < n) dma_wdata = wq[beat];
        else dma_req = 1'b0;
      end
    end
    dma_req = 1'b0;
    check_output("dma_beat_count", 64'(beat), 64'(n));
  endtask

  initial begin
    int k, kd, done_c, dfirst, s0, c_req, stall_cnt, cpu_done_c, seen;
    logic [63:0] rd, addr, wd;
    logic we;

    $display("[TB] start MEM_LAT=%0d", MEM_LAT);
    repeat (3) @(negedge clk);
    check_output("reset_ctrl", 64'({cpu_done, cpu_stall, dma_beat_done, dma_done, mem_wr, mem_tam}), 64'd0);
    check_output("reset_mem_addr", mem_addr, 64'd0);
    check_output("reset_cpu_rdata", cpu_rdata, 64'd0);
    rst = 1'b1;

    // First tie after reset: CPU wins, DMA follows after the IDLE cycle.
    fork
      cpu_access(1'b1, 64'h80, 64'h1111_2222_3333_4444, 2'd3, k, done_c, rd);
      dma_burst(1'b1, 64'h300, 4'd1, kd, dfirst);
    join
    check_output("tie1_cpu_done", 64'(done_c - k), 64'd2);
    check_output("tie1_dma_done", 64'(dfirst - k), 64'(2 + 1 + 2));
    ref_last_dma = 1;

    s0 = wr_log.size();
    cpu_access(1'b1, 64'h40, 64'hDEADBEEF, 2'd2, k, done_c, rd);
    ref_last_dma = 0;
    check_output("store_wr_count", 64'(wr_log.size() - s0), 64'd1);
    if (wr_log.size() > s0) begin
      check_output("store_wr_cycle", 64'(wr_log[s0].cyc - k), 64'd1);
      check_output("store_wr_addr", wr_log[s0].addr, 64'h40);
      check_output("store_wr_data", wr_log[s0].data, 64'hDEADBEEF);
      check_output("store_wr_tam", 64'(wr_log[s0].tam), 64'd2);
    end
    check_output("store_done_cycle", 64'(done_c - k), 64'd2);

    // Second tie: previous grant went to the CPU, so DMA goes first.
    fork
      cpu_access(1'b1, 64'h88, 64'h5555_6666_7777_8888, 2'd3, k, done_c, rd);
      dma_burst(1'b1, 64'h308, 4'd1, kd, dfirst);
    join
    check_output("tie2_dma_done", 64'(dfirst - kd), 64'd2);
    check_output("tie2_cpu_done", 64'(done_c - k), 64'(2 + 1 + 2));
    ref_last_dma = 0;

    s0 = wr_log.size();
    cpu_access(1'b0, 64'h40, 64'h0, 2'd3, k, done_c, rd);
    check_output("load_done_cycle", 64'(done_c - k), 64'(2 + MEM_LAT));
    check_output("load_data", rd, 64'hDEADBEEF);
    check_output("load_no_write", 64'(wr_log.size() - s0), 64'd0);

    s0 = wr_log.size();
    dma_burst(1'b1, 64'h100, 4'd3, k, dfirst);
    check_output("dmaw_wr_count", 64'(wr_log.size() - s0), 64'd3);
    for (int i = 0; i < 3 && s0 + i < wr_log.size(); i++) begin
      check_output("dmaw_addr", wr_log[s0+i].addr, 64'h100 + 64'(8 * i));
      check_output("dmaw_data", wr_log[s0+i].data, ref_read(64'h100 + 64'(8 * i)));
      check_output("dmaw_cycle", 64'(wr_log[s0+i].cyc - k), 64'(1 + 2 * i));
      check_output("dmaw_tam", 64'(wr_log[s0+i].tam), 64'd3);
    end
    check_output("dmaw_first_done", 64'(dfirst - k), 64'd2);

    dma_burst(1'b0, 64'h100, 4'd3, k, dfirst);
    check_output("dmar_first_done", 64'(dfirst - k), 64'(2 + MEM_LAT));

    // Randomized single CPU accesses against the reference contents.
    for (int it = 0; it < 12; it++) begin
      we   = 1'($urandom_range(0, 1));
      addr = 64'h1000 + 64'($urandom_range(0, 15) * 8);
      wd   = {$urandom, $urandom};
      s0   = wr_log.size();
      rd   = ref_read(addr);
      cpu_access(we, addr, wd, 2'($urandom_range(0, 3)), k, done_c, rd);
      check_output("rand_done_cycle", 64'(done_c - k), we ? 64'd2 : 64'(2 + MEM_LAT));
      if (we) begin
        check_output("rand_wr_count", 64'(wr_log.size() - s0), 64'd1);
        if (wr_log.size() > s0) check_output("rand_wr_data", wr_log[s0].data, wd);
      end else begin
        check_output("rand_load_data", rd, ref_read(addr));
      end
    end

    // 16-beat read burst that wraps past 2^64, with the CPU stalled behind it.
    c_req = 0; stall_cnt = 0; cpu_done_c = -1;
    fork
      dma_burst(1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 4'd0, kd, dfirst);
      begin
        repeat (7) @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h100; cpu_tam = 2'd3;
        c_req = cyc;
        for (int t = 0; t < 300; t++) begin
          @(negedge clk);
          if (cpu_stall) stall_cnt++;
          if (cpu_done) begin
            cpu_done_c = cyc;
            rd = cpu_rdata;
            break;
          end
        end
        cpu_req = 1'b0;
      end
    join
    kd = kd + 16 * (2 + MEM_LAT);
    check_output("wrap_stall_cycles", 64'(stall_cnt), 64'(kd + 1 - c_req));
    check_output("wrap_cpu_done", 64'(cpu_done_c), 64'(kd + 1 + 2 + MEM_LAT));
    check_output("wrap_cpu_data", rd, ref_read(64'h100));

    // Reset during the WAIT of a CPU load aborts it silently.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h200;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("arst_ctrl", 64'({cpu_done, cpu_stall, dma_beat_done, dma_done, mem_wr, mem_tam}), 64'd0);
    check_output("arst_mem_addr", mem_addr, 64'd0);
    check_output("arst_mem_wdata", mem_wdata, 64'd0);
    check_output("arst_cpu_rdata", cpu_rdata, 64'd0);
    check_output("arst_dma_rdata", dma_rdata, 64'd0);
    cpu_req = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_done) seen++;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (cpu_done) seen++;
    end
    check_output("arst_no_done", 64'(seen), 64'd0);
    cpu_access(1'b0, 64'h200, 64'h0, 2'd3, k, done_c, rd);
    check_output("arst_reload_cycle", 64'(done_c - k), 64'(2 + MEM_LAT));
    check_output("arst_reload_data", rd, ref_read(64'h200));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (synchronous-read, 64-bit) between two requesters: the CPU load/store path and a DMA/loader engine.
- Sequences each access through a fixed ACC/WAIT/RESP protocol that absorbs memory read latency.
- Arbitrates fairly between the requesters, and stalls the CPU control unit while it is not being served.
- Sits between the processor datapath (ALUOut register, B register, MDR) and the data memory.

Parameters:
- MEM_LAT, 1, read latency in cycles from the address being driven to mem_rdata being valid (range 1..4).
- DMA_STRIDE, 8, byte address increment per DMA beat.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held high until cpu_done
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  64  byte address
- cpu_wdata  in  64  store data
- cpu_tam  in  2  access size, passed through to mem_tam
- cpu_rdata  out  64  load data; registered, valid while cpu_done is high
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req high and CPU not the current owner (combinational)
- dma_req  in  1  burst request; held high until dma_done
- dma_we  in  1  burst direction
- dma_addr  in  64  burst start address
- dma_len  in  4  beat count; 0 means 16
- dma_wdata  in  64  write data for the current beat; sampled in ACC
- dma_rdata  out  64  read data of the current beat
- dma_beat_done  out  1  per-beat completion pulse
- dma_done  out  1  high together with the last dma_beat_done
- mem_addr  out  64  to the memory raddress and waddress
- mem_wdata  out  64  to the memory Datain
- mem_wr  out  1  memory write enable
- mem_tam  out  2  memory access size
- mem_rdata  in  64  from the memory Dataout

Behaviour:
- Reset: asynchronous, active-low.
  - All outputs go to 0; state goes to IDLE; last_grant = DMA; beat counter = 0.
  - An in-flight access or burst is aborted with no done pulse.
- States:
  - IDLE
  - ACC: address, data and size driven; mem_wr = latched we.
  - WAIT: MEM_LAT cycles, address held, mem_wr = 0.
  - RESP: done pulse.
- Request sampling: requests are sampled only in IDLE, on edge k. The address, we, wdata and size are latched at that edge.
- Arbitration in IDLE:
  - Only one request high: grant it.
  - Both high: grant the owner opposite last_grant, so the CPU wins the first tie after reset.
  - last_grant updates on each grant.
- Write timing: ACC in cycle k+1 with mem_wr = 1 for exactly one cycle, then RESP in cycle k+2 with done. Stores skip WAIT.
- Read timing:
  - ACC in cycle k+1, then WAIT for cycles k+2..k+1+MEM_LAT.
  - mem_rdata is captured into the rdata register on the edge leaving the last WAIT cycle.
  - RESP follows in cycle k+2+MEM_LAT.
- After RESP the state returns to IDLE for one cycle. Requesters must drop req by the edge ending the done cycle, otherwise a new access is taken. Peak rate is one CPU store per 3 cycles.
- DMA burst:
  - Beat count is latched from dma_len (0 means 16).
  - Each beat runs ACC(/WAIT)/RESP. RESP of a non-final beat goes directly to ACC of the next beat with no IDLE cycle; ownership is held for the whole burst.
  - mem_addr = start + beat*DMA_STRIDE, modulo 2^64 (wraps silently).
  - mem_tam = TAM_DOUBLE for all DMA beats.
  - dma_wdata is sampled in each beat's ACC cycle.
  - dma_done is high with the final dma_beat_done.
- CPU during a burst: a CPU request arriving mid-burst waits with cpu_stall high. It is granted in the IDLE after the burst even if dma_req is still high, because of the fairness rule.
- Idle values: mem_wr = 0 outside ACC. mem_addr and mem_wdata keep their last values; verification must not check them outside ACC/WAIT.
- cpu_rdata and dma_rdata: hold their value until the next read completes for that requester.
- Simultaneous events: if a new request arrives in the same cycle as RESP, it is considered at the next IDLE.

Decomposition:
- Package dmem_arb_pkg:
  - state_t enum {IDLE, ACC, WAIT, RESP}
  - owner_t enum {OWN_CPU, OWN_DMA}
  - TAM_DOUBLE constant
  - MEM_LAT range check
- Sub-module dmem_arb_burst_ctr:
  - Beat counter with load, decrement and last flag.
  - Address incrementer (start + beat*DMA_STRIDE).
- The top level holds the FSM, the latency counter, the latches and the arbitration.

Test Plan:
- CPU store, addr 0x40, wdata 0xDEADBEEF, MEM_LAT=1 → mem_wr high only in cycle k+1 with mem_addr=0x40; cpu_done in cycle k+2.
- CPU load, addr 0x40, mem model returns 0xDEADBEEF, MEM_LAT=2 → cpu_done in cycle k+4 with cpu_rdata=0xDEADBEEF; mem_wr never high.
- DMA write burst, addr 0x100, len 3 → mem_wr beats at 0x100, 0x108, 0x110 with no IDLE between beats; dma_done with the third dma_beat_done.
- cpu_req and dma_req raised in the same cycle after reset → CPU served first, then DMA. In a second tie, DMA is served first.
- DMA burst with dma_len=0 at addr 0xFFFF_FFFF_FFFF_FFF0 → 16 beats; addresses wrap to 0x0 at beat 2; 16 dma_beat_done pulses. CPU request mid-burst keeps cpu_stall high until the burst ends.
- rst low during the WAIT of a CPU load → all outputs 0 immediately, no cpu_done. After release, the re-issued load completes normally.
